multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/ctrl_pkg.sv | 40 ++++
 rtl/ctrl_decoder.sv | 60 ++++++
 rtl/multicycle_ctrl.sv | 158 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared state, opcode and writeback-select definitions for the multicycle controller
package ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC   = 2'b10;

    // Per-opcode control word produced by the decoder
    typedef struct packed {
        logic       sel_a;
        logic       sel_b;
        logic [1:0] wb_sel;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       is_jump;
        logic       reg_wr;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/ctrl_decoder.sv
// rtl/ctrl_decoder.sv - combinational opcode decoder: mux selects, class flags and illegal detect
module ctrl_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    output dec_t       dec_o
);

    // Map the captured opcode onto its control word; anything unlisted is illegal
    always_comb begin
        dec_o        = '0;
        dec_o.wb_sel = WB_ALU;
        case (opcode_i)
            OP_R: begin
                dec_o.reg_wr = 1'b1;
            end
            OP_I: begin
                dec_o.sel_b  = 1'b1;
                dec_o.reg_wr = 1'b1;
            end
            OP_LOAD: begin
                dec_o.sel_b   = 1'b1;
                dec_o.wb_sel  = WB_LOAD;
                dec_o.is_load = 1'b1;
                dec_o.reg_wr  = 1'b1;
            end
            OP_STORE: begin
                dec_o.sel_b    = 1'b1;
                dec_o.is_store = 1'b1;
            end
            OP_BRANCH: begin
                dec_o.sel_a     = 1'b1;
                dec_o.sel_b     = 1'b1;
                dec_o.is_branch = 1'b1;
            end
            OP_JAL: begin
                dec_o.sel_a   = 1'b1;
                dec_o.sel_b   = 1'b1;
                dec_o.wb_sel  = WB_PC;
                dec_o.is_jump = 1'b1;
                dec_o.reg_wr  = 1'b1;
            end
            OP_JALR: begin
                dec_o.sel_b   = 1'b1;
                dec_o.wb_sel  = WB_PC;
                dec_o.is_jump = 1'b1;
                dec_o.reg_wr  = 1'b1;
            end
            OP_AUIPC: begin
                dec_o.sel_a  = 1'b1;
                dec_o.sel_b  = 1'b1;
                dec_o.reg_wr = 1'b1;
            end
            default: begin
                dec_o.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - RV32I multicycle control FSM; CTRL_TIMEOUT_EN adds a MEM-wait timeout trap
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    input  logic        br_cond,
    input  logic        mem_ready,
    output logic        fetch_req,
    output logic        ir_en,
    output logic        sel_A,
    output logic        sel_B,
    output logic [1:0]  wb_sel,
    output logic        br_taken,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        reg_wr,
    output logic        pc_en,
    output logic        illegal,
    output logic        bus_err
);

    state_t     state_q, state_d;
    logic [6:0] opcode_q, opcode_d;
    logic       br_q, br_d;
    logic       timeout;
    dec_t       dec;

    // Only the opcode field steers the controller; the rest of the word feeds the datapath
    logic unused_ok;
    assign unused_ok = ^{instr[31:7], TIMEOUT_CYC};

    ctrl_decoder u_decoder (
        .opcode_i (opcode_q),
        .dec_o    (dec)
    );

`ifdef CTRL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // The final stalled MEM cycle is the one that brings the count up to TIMEOUT_CYC
    assign timeout = (cnt_q == CW'(TIMEOUT_CYC - 1));

    // Clear on the way into MEM, count every MEM cycle the memory leaves unanswered
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == EXEC) begin
            cnt_d = '0;
        end else if ((state_q == MEM) && !mem_ready) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Timeout counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Next-state and output decode; selects are only live in EXEC, MEM and WB
    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        br_d      = br_q;
        fetch_req = 1'b0;
        ir_en     = 1'b0;
        sel_A     = 1'b0;
        sel_B     = 1'b0;
        wb_sel    = WB_ALU;
        br_taken  = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        reg_wr    = 1'b0;
        pc_en     = 1'b0;
        illegal   = 1'b0;
        bus_err   = 1'b0;

        if ((state_q == EXEC) || (state_q == MEM) || (state_q == WB)) begin
            sel_A    = dec.sel_a;
            sel_B    = dec.sel_b;
            wb_sel   = dec.wb_sel;
            br_taken = dec.is_jump |
                       ((state_q == EXEC) ? (dec.is_branch & br_cond) : br_q);
        end

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                fetch_req = 1'b1;
                if (instr_valid) begin
                    ir_en    = 1'b1;
                    opcode_d = instr[6:0];
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                if (dec.illegal) begin
                    illegal = 1'b1;
                    state_d = FETCH;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                br_d    = dec.is_branch & br_cond;
                state_d = (dec.is_load || dec.is_store) ? MEM : WB;
            end
            MEM: begin
                mem_rd = dec.is_load;
                mem_wr = dec.is_store;
                if (mem_ready) begin
                    state_d = WB;
                end else if (timeout) begin
                    state_d = TRAP;
                end
            end
            WB: begin
                pc_en   = 1'b1;
                reg_wr  = dec.reg_wr;
                state_d = FETCH;
            end
            TRAP: begin
                bus_err = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, captured opcode and latched branch decision
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            opcode_q <= '0;
            br_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            br_q     <= br_d;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl (directed table, random model, corner sequences)
module tb_multicycle_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic        br_cond;
    logic        mem_ready;
    logic        fetch_req, ir_en, sel_A, sel_B, br_taken;
    logic [1:0]  wb_sel;
    logic        mem_rd, mem_wr, reg_wr, pc_en, illegal, bus_err;

    multicycle_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .br_cond     (br_cond),
        .mem_ready   (mem_ready),
        .fetch_req   (fetch_req),
        .ir_en       (ir_en),
        .sel_A       (sel_A),
        .sel_B       (sel_B),
        .wb_sel      (wb_sel),
        .br_taken    (br_taken),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .reg_wr      (reg_wr),
        .pc_en       (pc_en),
        .illegal     (illegal),
        .bus_err     (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         illegal;
        bit         sel_a;
        bit         sel_b;
        bit         chk_wb;
        logic [1:0] wb;
        bit         br;
        bit         reg_wr;
        int         lat;
        int         rd;
        int         wr;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        bit          brc;
        int          fdly;
        int          mdly;
        exp_t        e;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic void chk(string nm, int act, int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", nm, act, req);
    endfunction

    function automatic logic [12:0] outs();
        return {fetch_req, ir_en, sel_A, sel_B, wb_sel, br_taken,
                mem_rd, mem_wr, reg_wr, pc_en, illegal, bus_err};
    endfunction

    function automatic void add_vec(logic [31:0] ins, bit brc, int fdly, int mdly,
                                    bit ill, bit sa, bit sb, bit cwb, logic [1:0] wb,
                                    bit br, bit rw, int lat, int rd, int wr);
        vec_t v;
        v.instr = ins; v.brc = brc; v.fdly = fdly; v.mdly = mdly;
        v.e.illegal = ill; v.e.sel_a = sa; v.e.sel_b = sb; v.e.chk_wb = cwb;
        v.e.wb = wb; v.e.br = br; v.e.reg_wr = rw; v.e.lat = lat; v.e.rd = rd; v.e.wr = wr;
        vecs.push_back(v);
    endfunction

    // Behavioural expectation for one instruction from the opcode table and memory wait
    function automatic exp_t model(logic [6:0] op, bit brc, int mdly);
        exp_t e;
        e = '{default: 0};
        case (op)
            7'b0110011: begin e.reg_wr = 1; e.chk_wb = 1; e.wb = 2'b00; end
            7'b0010011: begin e.sel_b = 1; e.reg_wr = 1; e.chk_wb = 1; e.wb = 2'b00; end
            7'b0000011: begin e.sel_b = 1; e.reg_wr = 1; e.chk_wb = 1; e.wb = 2'b01; e.rd = mdly + 1; end
            7'b0100011: begin e.sel_b = 1; e.wr = mdly + 1; end
            7'b1100011: begin e.sel_a = 1; e.sel_b = 1; e.br = brc; end
            7'b1101111: begin e.sel_a = 1; e.sel_b = 1; e.chk_wb = 1; e.wb = 2'b10; e.br = 1; e.reg_wr = 1; end
            7'b1100111: begin e.sel_b = 1; e.chk_wb = 1; e.wb = 2'b10; e.br = 1; e.reg_wr = 1; end
            7'b0010111: begin e.sel_a = 1; e.sel_b = 1; e.chk_wb = 1; e.wb = 2'b00; e.reg_wr = 1; end
            default:    e.illegal = 1;
        endcase
        e.lat = (e.rd != 0 || e.wr != 0) ? 5 + mdly : 4;
        return e;
    endfunction

    // Drive one instruction through the FSM from a posedge+1 point, observe at negedges
    task automatic run_instr(input string nm, input logic [31:0] ins, input bit brc,
                             input int fdly, input int mdly, input exp_t e,
                             output int o_ir, output int o_pc);
        int ir_n, pc_n, ill_n, rd_n, wr_n, mseen, fwait, ret_cyc, ill_cyc, budget;
        bit sa_s, sb_s, br_s, rw_s, ok, done;
        logic [1:0] wb_s;
        ir_n = 0; pc_n = 0; ill_n = 0; rd_n = 0; wr_n = 0; mseen = 0; fwait = 0;
        ret_cyc = -1; ill_cyc = -1; o_ir = -1; o_pc = -1;
        sa_s = 0; sb_s = 0; br_s = 0; rw_s = 0; wb_s = 2'b00; ok = 1; done = 0;
        budget = 20 + fdly + mdly;
        br_cond = brc;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (fetch_req && ir_n > 0) begin
                instr_valid = 1'b0;
                mem_ready   = 1'b0;
                ret_cyc     = cyc;
                done        = 1;
                break;
            end
            if (fetch_req) begin
                instr_valid = (fwait >= fdly);
                instr       = instr_valid ? ins : $urandom();
                fwait++;
            end else begin
                instr_valid = 1'($urandom_range(0, 1));
                instr       = $urandom();
            end
            if (mem_rd || mem_wr) mem_ready = (mseen >= mdly);
            else mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (ir_en) begin ir_n++; o_ir = cyc; end
            if (pc_en) begin
                pc_n++; o_pc = cyc;
                sa_s = sel_A; sb_s = sel_B; wb_s = wb_sel; br_s = br_taken; rw_s = reg_wr;
            end
            if (illegal) begin ill_n++; ill_cyc = cyc; end
            if (mem_rd) rd_n++;
            if (mem_wr) wr_n++;
            if (mem_rd || mem_wr) mseen++;
            if (mem_rd && mem_wr) ok = 0;
            if (reg_wr && !pc_en) ok = 0;
            if ((fetch_req || illegal) &&
                (sel_A || sel_B || wb_sel != 2'b00 || br_taken || mem_rd || mem_wr || pc_en)) ok = 0;
            if (bus_err) ok = 0;
            @(posedge clk); #1;
        end
        chk({nm, " back in FETCH within budget"}, done, 1);
        chk({nm, " ir_en pulses"}, ir_n, 1);
        chk({nm, " output invariants"}, ok, 1);
        if (e.illegal) begin
            chk({nm, " illegal pulses"}, ill_n, 1);
            chk({nm, " illegal one cycle after ir_en"}, ill_cyc - o_ir, 1);
            chk({nm, " pc_en on illegal"}, pc_n, 0);
            chk({nm, " FETCH after illegal"}, ret_cyc - ill_cyc, 1);
        end else begin
            chk({nm, " illegal pulses"}, ill_n, 0);
            chk({nm, " pc_en pulses"}, pc_n, 1);
            chk({nm, " latency"}, o_pc - o_ir + 1, e.lat);
            chk({nm, " mem_rd cycles"}, rd_n, e.rd);
            chk({nm, " mem_wr cycles"}, wr_n, e.wr);
            chk({nm, " sel_A"}, sa_s, e.sel_a);
            chk({nm, " sel_B"}, sb_s, e.sel_b);
            if (e.chk_wb) chk({nm, " wb_sel"}, wb_s, e.wb);
            chk({nm, " br_taken"}, br_s, e.br);
            chk({nm, " reg_wr"}, rw_s, e.reg_wr);
            chk({nm, " FETCH after WB"}, ret_cyc - o_pc, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   o_ir, o_pc;
        logic [31:0] w;
        logic [6:0]  op;
        bit   brc;
        int   fd, md;
        exp_t e;

        // ins, br, fdly, mdly | illegal, sel_A, sel_B, chk_wb, wb, br_taken, reg_wr, latency, rd cycles, wr cycles
        add_vec(32'h00B50533, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 1, 4, 0, 0);
        add_vec(32'h00052283, 0, 0, 3, 0, 0, 1, 1, 2'b01, 0, 1, 8, 4, 0);
        add_vec(32'h00208463, 1, 0, 0, 0, 1, 1, 0, 2'b00, 1, 0, 4, 0, 0);
        add_vec(32'h00208463, 0, 1, 0, 0, 1, 1, 0, 2'b00, 0, 0, 4, 0, 0);
        add_vec(32'hFFFFFFFF, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        add_vec(32'h00150513, 1, 0, 0, 0, 0, 1, 1, 2'b00, 0, 1, 4, 0, 0);
        add_vec(32'h00A52023, 0, 2, 0, 0, 0, 1, 0, 2'b00, 0, 0, 5, 0, 1);
        add_vec(32'h008000EF, 0, 0, 0, 0, 1, 1, 1, 2'b10, 1, 1, 4, 0, 0);
        add_vec(32'h000080E7, 0, 0, 0, 0, 0, 1, 1, 2'b10, 1, 1, 4, 0, 0);
        add_vec(32'h00000517, 1, 0, 0, 0, 1, 1, 1, 2'b00, 0, 1, 4, 0, 0);
        add_vec(32'h00A52023, 1, 0, 2, 0, 0, 1, 0, 2'b00, 0, 0, 7, 0, 3);
        add_vec(32'h00000000, 0, 3, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        add_vec(32'h00052283, 0, 0, 0, 0, 0, 1, 1, 2'b01, 0, 1, 5, 1, 0);
        add_vec(32'h00209463, 1, 0, 0, 0, 1, 1, 0, 2'b00, 1, 0, 4, 0, 0);

        rst_n = 1'b0; instr_valid = 1'b0; instr = '0; br_cond = 1'b0; mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 instr_valid = 1'b1; mem_ready = 1'b1; br_cond = 1'b1; instr = 32'hFFFFFFFF;
        @(negedge clk);
        chk("reset outputs", outs(), 0);
        @(posedge clk); #1;
        instr_valid = 1'b0; mem_ready = 1'b0; br_cond = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_instr($sformatf("vec%0d", i), vecs[i].instr, vecs[i].brc,
                      vecs[i].fdly, vecs[i].mdly, vecs[i].e, o_ir, o_pc);
            if (i == 0) begin
                chk("add ir_en cycle after reset", o_ir, 1);
                chk("add pc_en cycle after reset", o_pc, 4);
            end
        end

        // Reset arriving in the middle of a load's MEM wait
        begin
            bit seen;
            seen = 0;
            instr = 32'h00052283; instr_valid = 1'b1; mem_ready = 1'b0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (mem_rd) begin seen = 1; break; end
                @(posedge clk); #1 instr_valid = 1'b0;
            end
            chk("rst-mem reached MEM", seen, 1);
            @(posedge clk); #1;
            instr_valid = 1'b0; rst_n = 1'b0;
            @(negedge clk);
            chk("rst-mem mem_rd before reset edge", mem_rd, 1);
            @(posedge clk); #1 rst_n = 1'b1;
            @(negedge clk);
            chk("rst-mem outputs after reset edge", outs(), 0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("rst-mem fetch_req after release", fetch_req, 1);
            @(posedge clk); #1;
        end

        for (int i = 0; i < 40; i++) begin
            w   = $urandom();
            case ($urandom_range(0, 9))
                0: op = 7'b0110011;
                1: op = 7'b0010011;
                2: op = 7'b0000011;
                3: op = 7'b0100011;
                4: op = 7'b1100011;
                5: op = 7'b1101111;
                6: op = 7'b1100111;
                7: op = 7'b0010111;
                default: op = 7'($urandom_range(0, 127));
            endcase
            w[6:0] = op;
            brc = 1'($urandom_range(0, 1));
            fd  = $urandom_range(0, 3);
            md  = $urandom_range(0, TO - 1);
            e   = model(op, brc, md);
            run_instr($sformatf("rand%0d op=%b", i, op), w, brc, fd, md, e, o_ir, o_pc);
        end

`ifdef CTRL_TIMEOUT_EN
        // A store that never completes must trap after TO stalled MEM cycles
        begin
            int wr_n;
            bit trapped;
            wr_n = 0; trapped = 0;
            instr = 32'h00A52023; instr_valid = 1'b1; mem_ready = 1'b0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (mem_wr) wr_n++;
                if (bus_err) begin trapped = 1; break; end
                @(posedge clk); #1 instr_valid = 1'b0;
            end
            chk("timeout trapped", trapped, 1);
            chk("timeout MEM cycles before trap", wr_n, TO);
            chk("trap outputs", outs(), 1);
            repeat (6) begin
                @(posedge clk); #1;
                instr_valid = 1'b1; mem_ready = 1'b1;
            end
            @(negedge clk);
            chk("trap sticky", outs(), 1);
            @(posedge clk); #1 rst_n = 1'b0; instr_valid = 1'b0; mem_ready = 1'b0;
            @(negedge clk);
            chk("trap held until reset edge", bus_err, 1);
            @(posedge clk); #1 rst_n = 1'b1;
            @(negedge clk);
            chk("trap cleared by reset", outs(), 0);
        end
`else
        // Without the timeout a long MEM wait simply completes
        e = model(7'b0100011, 1'b0, 30);
        run_instr("long wait sw", 32'h00A52023, 1'b0, 0, 30, e, o_ir, o_pc);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
